positaccum_feeder: RTL

POSITACCUM_FEEDER -- requirements
Module: positaccum_feeder

---
 rtl/positaccum_feeder_if.sv | 24 ++
 rtl/positaccum_feeder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/positaccum_feeder_if.sv
// Term stream and sum handshake bundle for positaccum_feeder.
// slave  : the feeder (consumes terms, produces sums)
// master : the producer/consumer on the other side
interface positaccum_feeder_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] sum;
  logic        sum_inf;
  logic        sum_zero;
  logic        sum_valid;
  logic        sum_ready;

  modport master (
    output in_data, in_valid, in_last, sum_ready,
    input  in_ready, sum, sum_inf, sum_zero, sum_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, sum_ready,
    output in_ready, sum, sum_inf, sum_zero, sum_valid
  );
endinterface

// File: rtl/positaccum_feeder.sv
// positaccum_feeder: sequences a stream of posit terms into a pipelined
// posit accumulator one term at a time, then presents the final sum.
// Each sum first holds acc_clear for LOOP_LATENCY cycles to flush the
// accumulator's feedback pipeline. All outputs are registered.
// Optional: define POSITACCUM_FEEDER_TIMEOUT_EN to add a WAIT watchdog that,
// after TIMEOUT cycles without acc_done, sets a sticky error and returns
// NaR (0x80000000, sum_inf=1) as the sum.
module positaccum_feeder #(
  parameter int LOOP_LATENCY = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  positaccum_feeder_if.slave   io,
  output logic [31:0]          acc_in1,
  output logic                 acc_start,
  output logic                 acc_clear,
  input  logic [31:0]          acc_result,
  input  logic                 acc_inf,
  input  logic                 acc_zero,
  input  logic                 acc_done,
  output logic [15:0]          count,
  output logic                 busy,
  output logic                 error
);

  localparam int CW = $clog2(LOOP_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, OUTPUT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] clr_cnt;
  logic          last;
  logic          accept;
  logic          capture;
  logic          tmo;
  logic          wd_hit;

`ifdef POSITACCUM_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == TW'(TIMEOUT - 1));

  // Watchdog: restarts on every issued term, counts WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wd_cnt <= '0;
    else if (accept)                  wd_cnt <= '0;
    else if (state == WAIT && !wd_hit) wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky error until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      error <= 1'b0;
    else if (tmo) error <= 1'b1;
  end
`else
  assign wd_hit = 1'b0;
  assign error  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and the single-cycle events that steer the datapath.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE:   if (io.in_valid) state_n = CLEAR;
      CLEAR:  if (clr_cnt <= CW'(1)) state_n = ISSUE;
      ISSUE:  if (io.in_valid && io.in_ready) begin
                accept  = 1'b1;
                state_n = WAIT;
              end
      WAIT:   if (acc_done) begin
                if (last) begin
                  capture = 1'b1;
                  state_n = OUTPUT;
                end else begin
                  state_n = ISSUE;
                end
              end else if (wd_hit) begin
                tmo     = 1'b1;
                state_n = OUTPUT;
              end
      OUTPUT: if (io.sum_valid && io.sum_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs: status flags follow the next state so they line up
  // with the state they describe; data registers load on accept/capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.in_ready  <= 1'b0;
      io.sum_valid <= 1'b0;
      io.sum       <= '0;
      io.sum_inf   <= 1'b0;
      io.sum_zero  <= 1'b1;
      acc_in1      <= '0;
      acc_start    <= 1'b0;
      acc_clear    <= 1'b0;
      busy         <= 1'b0;
      count        <= '0;
      clr_cnt      <= '0;
      last         <= 1'b0;
    end else begin
      io.in_ready  <= (state_n == ISSUE);
      io.sum_valid <= (state_n == OUTPUT);
      acc_clear    <= (state_n == CLEAR);
      acc_start    <= accept;
      busy         <= (state_n != IDLE);

      if (state == IDLE && state_n == CLEAR) begin
        clr_cnt <= CW'(LOOP_LATENCY);
        count   <= '0;
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt - 1'b1;
      end

      // acc_in1 then holds untouched until the next accept.
      if (accept) begin
        acc_in1 <= io.in_data;
        last    <= io.in_last;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end

      if (capture) begin
        io.sum      <= acc_result;
        io.sum_inf  <= acc_inf;
        io.sum_zero <= acc_zero;
      end else if (tmo) begin
        io.sum      <= 32'h8000_0000;
        io.sum_inf  <= 1'b1;
        io.sum_zero <= 1'b0;
      end
    end
  end

endmodule
